// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, frame constants, tag builder.
// Optional tag-frame feature is selected by UART_TX_ARB_TAG_EN.
package uart_tx_arbiter_pkg;

  localparam logic [3:0] UART_TAG_HI     = 4'hA;
  localparam int         UART_FRAME_BITS = 10;

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_TAG_START,
    S_TAG_WAIT_BUSY,
    S_TAG_WAIT_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;
`endif

  function automatic logic [7:0] tag_byte(input logic [2:0] idx);
    return {UART_TAG_HI, 1'b0, idx};
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
// Pure logic, zero latency; no backpressure of its own.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W:0] sum;

  // Walk offsets from farthest to nearest so the closest valid index wins last.
  always_comb begin
    winner = '0;
    sum    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (req_valid[sum[IDX_W-1:0]]) winner = sum[IDX_W-1:0];
    end
  end

  assign found = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NUM_REQ byte sources; ack/tx_start one cycle after grant.
// Grants only while tx_busy is low; UART_TX_ARB_TAG_EN prefixes each byte with a tag frame.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int BUSY_TO = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 arb_busy,
  output logic                 tx_err
);

  localparam int TW = $clog2(BUSY_TO + 1);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [TW-1:0]    timer;
  logic             found;
  logic [IDX_W-1:0] winner;
  logic [7:0]       req_byte [NUM_REQ];
`ifdef UART_TX_ARB_TAG_EN
  logic [7:0]       data_hold;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign req_byte[i] = req_data[8*i +: 8];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .found     (found),
    .winner    (winner)
  );

  assign arb_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      timer     <= '0;
      req_ack   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      grant_idx <= '0;
      tx_err    <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
      data_hold <= 8'h00;
`endif
    end else begin
      req_ack  <= '0;
      tx_start <= 1'b0;
      tx_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!tx_busy && found) begin
            grant_idx <= winner;
            rr_ptr    <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            req_ack   <= NUM_REQ'(1) << winner;
            tx_start  <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
            tx_data   <= tag_byte(3'(winner));
            data_hold <= req_byte[winner];
            state     <= S_TAG_START;
`else
            tx_data   <= req_byte[winner];
            state     <= S_START;
`endif
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT_BUSY;
        end
        // timer == BUSY_TO-2 here means tx_start was BUSY_TO-1 cycles ago
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (timer == TW'(BUSY_TO - 2)) begin
            tx_err <= 1'b1;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) state <= S_IDLE;
        end
`ifdef UART_TX_ARB_TAG_EN
        S_TAG_START: begin
          timer <= '0;
          state <= S_TAG_WAIT_BUSY;
        end
        S_TAG_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_TAG_WAIT_DONE;
          end else if (timer == TW'(BUSY_TO - 2)) begin
            tx_err <= 1'b1;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_TAG_WAIT_DONE: begin
          if (!tx_busy) begin
            tx_data  <= data_hold;
            tx_start <= 1'b1;
            state    <= S_START;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a serial transmitter model and line decoder.
// Honours UART_TX_ARB_TAG_EN for the expected frame sequence.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NR  = 4;
  localparam int IW  = 2;
  localparam int BTO = 4;
  localparam int CPB = 4;
`ifdef UART_TX_ARB_TAG_EN
  localparam int FPG = 2;
`else
  localparam int FPG = 1;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ack;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy = 1'b0;
  logic [IW-1:0]   grant_idx;
  logic            arb_busy;
  logic            tx_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .BUSY_TO(BTO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_idx (grant_idx),
    .arb_busy  (arb_busy),
    .tx_err    (tx_err)
  );

  // Transmitter model: busy the cycle after tx_start, 10 bits of CPB cycles each.
  logic       txd = 1'b1;
  logic [9:0] m_sh = '0;
  int         m_cyc = 0;
  int         m_bit = 0;
  bit         tx_live = 1'b1;
  int         overlap = 0;

  always @(posedge clk) begin
    if (tx_start && tx_busy) overlap <= overlap + 1;
    if (tx_busy) begin
      if (m_cyc == CPB - 1) begin
        m_cyc <= 0;
        if (m_bit == UART_FRAME_BITS - 1) begin
          tx_busy <= 1'b0;
          txd     <= 1'b1;
        end else begin
          m_bit <= m_bit + 1;
          m_sh  <= m_sh >> 1;
          txd   <= m_sh[1];
        end
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end else if (tx_start && tx_live) begin
      tx_busy <= 1'b1;
      m_sh    <= {1'b1, tx_data, 1'b0};
      m_bit   <= 0;
      m_cyc   <= 0;
      txd     <= 1'b0;
    end
  end

  // Line decoder: mid-bit sampling from the detected start edge.
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_sh = '0;
  int         frame_err = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (!rx_act) begin
      if (!txd) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % CPB == CPB / 2) rx_sh <= {txd, rx_sh[9:1]};
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        rx_act <= 1'b0;
        if (txd != 1'b1 || rx_sh[1] != 1'b0) frame_err <= frame_err + 1;
        rx_q.push_back(rx_sh[9:2]);
      end
    end
  end

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         ack_w_err = 0;
  logic [NR-1:0] prev_ack = '0;
  int         ack_log[$];
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         err_cyc = -1;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (req_ack != '0) begin
      for (int i = 0; i < NR; i++) if (req_ack[i]) ack_log.push_back(i);
      if ($countones(req_ack) != 1) ack_w_err++;
    end
    if ((req_ack & prev_ack) != '0) ack_w_err++;
    prev_ack = req_ack;
    if (tx_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (tx_err) err_cyc = cyc;
  endtask

  task automatic exp_push(input logic [2:0] idx, input logic [7:0] data);
`ifdef UART_TX_ARB_TAG_EN
    exp_q.push_back({4'hA, 1'b0, idx});
`endif
    exp_q.push_back(data);
  endtask

  task automatic run_reqs(input logic [NR-1:0] mask, input bit hold, input int n_acks, input int budget);
    int got = 0;
    int n = 0;
    req_valid = mask;
    while (got < n_acks && n < budget) begin
      tick();
      n++;
      if (req_ack != '0) begin
        got++;
        if (!hold) req_valid = req_valid & ~req_ack;
      end
    end
    if (hold) req_valid = '0;
    chk("ack_count", got, n_acks);
  endtask

  task automatic wait_lvl(input logic v);
    int n = 0;
    while (tx_busy !== v && n < 500) begin
      tick();
      n++;
    end
    chk("tx_busy_wait", tx_busy, v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((arb_busy || tx_busy || rx_act) && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_wait", {arb_busy, tx_busy, rx_act}, 0);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nframes"}, rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk({tag, "_frame"}, (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD, exp_q[k]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) tick();
    chk("rst_ack", req_ack, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_grant", grant_idx, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_err", tx_err, 0);
    reset = 1'b1;
    tick();

    // 1: single request, one-cycle latency, serial frame, arb_busy release
    req_data[23:16] = 8'h5A;
    req_valid = 4'b0100;
    tick();
    chk("t1_ack", req_ack, 4'b0100);
    chk("t1_start", tx_start, 1);
    chk("t1_grant", grant_idx, 2);
`ifdef UART_TX_ARB_TAG_EN
    chk("t1_txdata", tx_data, 8'hA2);
`else
    chk("t1_txdata", tx_data, 8'h5A);
`endif
    chk("t1_arb_busy", arb_busy, 1);
    req_valid = '0;
    exp_push(3'd2, 8'h5A);
    tick();
    chk("t1_start_pulse", tx_start, 0);
    chk("t1_ack_pulse", req_ack, 0);
    for (int f = 0; f < FPG; f++) begin
      wait_lvl(1'b1);
      wait_lvl(1'b0);
    end
    chk("t1_arb_hold", arb_busy, 1);
    tick();
    chk("t1_arb_fall", arb_busy, 0);
    check_frames("t1");

    // 2: all four continuously valid from a fresh pointer
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    ack_log.delete();
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
    run_reqs(4'b1111, 1'b1, 5, 3000);
    chk("t2_g0", ack_log.size() > 0 ? ack_log[0] : -1, 0);
    chk("t2_g1", ack_log.size() > 1 ? ack_log[1] : -1, 1);
    chk("t2_g2", ack_log.size() > 2 ? ack_log[2] : -1, 2);
    chk("t2_g3", ack_log.size() > 3 ? ack_log[3] : -1, 3);
    chk("t2_g4", ack_log.size() > 4 ? ack_log[4] : -1, 0);
    exp_push(3'd0, 8'h10);
    exp_push(3'd1, 8'h11);
    exp_push(3'd2, 8'h12);
    exp_push(3'd3, 8'h13);
    exp_push(3'd0, 8'h10);
    wait_idle();
    check_frames("t2");

    // 3: wrap after grant 3 with req 1 and 3 pending
    ack_log.delete();
    req_data[31:24] = 8'h33;
    req_data[15:8]  = 8'h11;
    run_reqs(4'b1000, 1'b0, 1, 1000);
    run_reqs(4'b1010, 1'b0, 2, 2000);
    chk("t3_g0", ack_log.size() > 0 ? ack_log[0] : -1, 3);
    chk("t3_g1", ack_log.size() > 1 ? ack_log[1] : -1, 1);
    chk("t3_g2", ack_log.size() > 2 ? ack_log[2] : -1, 3);
    exp_push(3'd3, 8'h33);
    exp_push(3'd1, 8'h11);
    exp_push(3'd3, 8'h33);
    wait_idle();
    check_frames("t3");

    // 4: transmitter never answers
    begin
      int s0;
      int n = 0;
      tx_live = 1'b0;
      s0 = start_cnt;
      err_cyc = -1;
      req_data[7:0] = 8'h77;
      run_reqs(4'b0001, 1'b0, 1, 100);
      while (!tx_err && n < 50) begin
        tick();
        n++;
      end
      chk("t4_err_seen", tx_err, 1);
      chk("t4_err_lat", err_cyc - start_cyc, BTO);
      chk("t4_idle", arb_busy, 0);
      tick();
      chk("t4_err_pulse", tx_err, 0);
      chk("t4_starts", start_cnt - s0, 1);
      tx_live = 1'b1;
      ack_log.delete();
      req_data[23:16] = 8'h3C;
      run_reqs(4'b0100, 1'b0, 1, 100);
      chk("t4_regrant", ack_log.size() > 0 ? ack_log[0] : -1, 2);
      exp_push(3'd2, 8'h3C);
      wait_idle();
      check_frames("t4");
    end

    // 5: reset while a frame is in flight
    ack_log.delete();
    req_data[15:8] = 8'h99;
    run_reqs(4'b0010, 1'b0, 1, 100);
    wait_lvl(1'b1);
    repeat (3) tick();
    chk("t5_pre_busy", arb_busy, 1);
    reset = 1'b0;
    req_data[7:0]   = 8'h01;
    req_data[31:24] = 8'h04;
    req_valid = 4'b1001;
    tick();
    reset = 1'b1;
    chk("t5_ack", req_ack, 0);
    chk("t5_start", tx_start, 0);
    chk("t5_data", tx_data, 8'h00);
    chk("t5_grant", grant_idx, 0);
    chk("t5_arb_busy", arb_busy, 0);
    chk("t5_err", tx_err, 0);
    chk("t5_line_busy", tx_busy, 1);
    wait_lvl(1'b0);
    chk("t5_no_grant_busy", ack_log.size(), 1);
    rx_q.delete();
    exp_q.delete();
    run_reqs(4'b1001, 1'b0, 2, 2000);
    chk("t5_g0", ack_log.size() > 1 ? ack_log[1] : -1, 0);
    chk("t5_g1", ack_log.size() > 2 ? ack_log[2] : -1, 3);
    exp_push(3'd0, 8'h01);
    exp_push(3'd3, 8'h04);
    wait_idle();
    check_frames("t5");

    // 6: tag prefix (or plain frame when the feature is off)
    ack_log.delete();
    req_data[23:16] = 8'hC3;
    run_reqs(4'b0100, 1'b0, 1, 100);
    wait_idle();
    chk("t6_single_ack", ack_log.size(), 1);
`ifdef UART_TX_ARB_TAG_EN
    chk("t6_nframes", rx_q.size(), 2);
    chk("t6_tag", rx_q.size() > 0 ? 32'(rx_q[0]) : 32'hDEAD, 8'hA2);
    chk("t6_data", rx_q.size() > 1 ? 32'(rx_q[1]) : 32'hDEAD, 8'hC3);
`else
    chk("t6_nframes", rx_q.size(), 1);
    chk("t6_data", rx_q.size() > 0 ? 32'(rx_q[0]) : 32'hDEAD, 8'hC3);
`endif
    rx_q.delete();

    chk("framing", frame_err, 0);
    chk("overlap", overlap, 0);
    chk("ack_width", ack_w_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
